// File: rtl/shift_exec_pipe_if.sv
// shift_exec_pipe_if: valid/ready operand and result bus of the shift execute pipe.
interface shift_exec_pipe_if #(parameter int N = 32, parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [4:0]       in_shamt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [CNT_W-1:0] op_count;
    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, op_count
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, op_count
    );
endinterface

// File: rtl/shift_exec_pipe.sv
// shift_exec_pipe: two-stage registered SLL/SRL/SRA execute stage with valid/ready flow and consumed-op counter.
// Define SHIFT_EXEC_ROTATE_EN to make op 11 a rotate right; otherwise op 11 passes the operand through.
module shift_exec_pipe #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    shift_exec_pipe_if.slave bus
);
    logic             v1, v2, adv2, accept, consume;
    logic [N-1:0]     s1_data, sra, ror, res, out_data;
    logic [4:0]       s1_shamt;
    logic [1:0]       s1_op;
    logic [CNT_W-1:0] op_count;

    assign adv2          = v1 && (!v2 || bus.out_ready);
    assign bus.in_ready  = !v1 || adv2;
    assign accept        = bus.in_valid && bus.in_ready;
    assign consume       = v2 && bus.out_ready;
    assign bus.out_valid = v2;
    assign bus.out_data  = out_data;
    assign bus.op_count  = op_count;

    // kept as its own assignment so the signed shift is not turned logical by a ternary
    assign sra = $signed(s1_data) >>> s1_shamt;
`ifdef SHIFT_EXEC_ROTATE_EN
    assign ror = (s1_data >> s1_shamt) | (s1_data << (6'd32 - {1'b0, s1_shamt}));
`else
    assign ror = s1_data;
`endif

    always_comb
        res = s1_op == 2'b00 ? s1_data << s1_shamt :
              s1_op == 2'b01 ? s1_data >> s1_shamt :
              s1_op == 2'b10 ? sra : ror;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_op    <= '0;
            out_data <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                s1_data  <= bus.in_data;
                s1_shamt <= bus.in_shamt;
                s1_op    <= bus.in_op;
                v1       <= 1'b1;
            end else if (adv2)
                v1 <= 1'b0;
            if (adv2) begin
                out_data <= res;
                v2       <= 1'b1;
            end else if (consume)
                v2 <= 1'b0;
            if (consume)
                op_count <= op_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_shift_exec_pipe.sv
// tb_shift_exec_pipe: directed vectors into a scoreboard queue, checked by an independent output monitor.
module tb_shift_exec_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic        held = 1'b0;
    logic [31:0] held_d = '0;

    shift_exec_pipe_if bus ();
    shift_exec_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: pops on every handshake and checks held data under backpressure
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held)
                chk("hold_stable", {bus.out_valid, bus.out_data[30:0]} ^ {1'b0, held_d[30:0]} ^ {1'b0, bus.out_data[30:0]},
                    {1'b1, held_d[30:0]});
            if (held)
                chk("hold_data", bus.out_data, held_d);
            held   = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0)
                    chk("unexpected_result", bus.out_data, 32'hxxxx_xxxx);
                else
                    chk("result", bus.out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op, input logic [31:0] e);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_op    = op;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    logic [31:0] bp_d[4] = '{32'h1234_5678, 32'h8765_4321, 32'h0F0F_0F0F, 32'hF000_0001};
    logic [4:0]  bp_s[4] = '{5'd4, 5'd8, 5'd1, 5'd31};
    logic [1:0]  bp_o[4] = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic [31:0] bp_e[4] = '{32'h2345_6780, 32'h0087_6543, 32'h0787_8787, 32'hFFFF_FFFF};

    initial begin
        logic [15:0] c0;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_op_count", {16'd0, bus.op_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

        // latency: result visible after the edge following the accept edge
        send(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
        bus.in_valid = 1'b0;
        chk("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_data", bus.out_data, 32'h0000_0001);
        drain();

        send(32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
        send(32'h0000_00FF, 5'd8,  2'b00, 32'h0000_FF00);
        send(32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
        send(32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF);
        send(32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF);
        send(32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF);
        send(32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF);
        send(32'h7FFF_FFFF, 5'd4,  2'b10, 32'h07FF_FFFF);
        send(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
        send(32'hF000_000F, 5'd4,  2'b01, 32'h0F00_0000);
`ifdef SHIFT_EXEC_ROTATE_EN
        send(32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000);
        send(32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F);
`else
        send(32'h0000_0001, 5'd1,  2'b11, 32'h0000_0001);
        send(32'h0000_00F1, 5'd4,  2'b11, 32'h0000_00F1);
`endif
        bus.in_valid = 1'b0;
        drain();

        // eight back-to-back ops must all be consumed two edges after the last accept
        c0 = bus.op_count;
        for (int i = 0; i < 8; i++)
            send(32'h0000_0001 << i, 5'(i), 2'b00, 32'h0000_0001 << (2 * i));
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("stream_count", {16'd0, bus.op_count}, {16'd0, c0 + 16'd8});
        drain();

        // backpressure: two accepts fill S1/S2, then in_ready must drop
        bus.out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp_d[n];
            bus.in_shamt = bp_s[n];
            bus.in_op    = bp_o[n];
            @(negedge clk);
            if (bus.in_ready && n < 4) begin
                exp_q.push_back(bp_e[n]);
                n++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepts", n, 2);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        for (int i = n; i < 4; i++) send(bp_d[i], bp_s[i], bp_o[i], bp_e[i]);
        bus.in_valid = 1'b0;
        drain();

        // asynchronous reset with both stages full
        bus.out_ready = 1'b0;
        send(32'h0000_00AA, 5'd1, 2'b00, 32'h0000_0154);
        send(32'h0000_00BB, 5'd1, 2'b00, 32'h0000_0176);
        bus.in_valid = 1'b0;
        #2;
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_op_count", {16'd0, bus.op_count}, 32'd0);
        chk("mid_rst_out_data", bus.out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(32'h0000_0003, 5'd2, 2'b00, 32'h0000_000C);
        bus.in_valid = 1'b0;
        drain();
        chk("post_rst_count", {16'd0, bus.op_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
